// File: rtl/mcycle_pkg.sv
// Shared definitions for the MCycle two-port arbiter: operation codes and FSM state encoding.
package mcycle_pkg;

    localparam logic [1:0] MUL_S = 2'b00;
    localparam logic [1:0] MUL_U = 2'b01;
    localparam logic [1:0] DIV_S = 2'b10;
    localparam logic [1:0] DIV_U = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mcycle_arbiter_if.sv
// Bundle of the two requester ports, the shared response and the MCycle-side signals.
interface mcycle_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0;
    logic [1:0]       op0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             gnt0;
    logic             done0;

    logic             req1;
    logic [1:0]       op1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             gnt1;
    logic             done1;

    logic [WIDTH-1:0] resp_result1;
    logic [WIDTH-1:0] resp_result2;
    logic             busy;

    logic             mc_start;
    logic [1:0]       mc_op;
    logic [WIDTH-1:0] mc_operand1;
    logic [WIDTH-1:0] mc_operand2;
    logic [WIDTH-1:0] mc_result1;
    logic [WIDTH-1:0] mc_result2;
    logic             mc_busy;

    // arbiter view
    modport slave (
        input  req0, op0, a0, b0, req1, op1, a1, b1,
        input  mc_result1, mc_result2, mc_busy,
        output gnt0, gnt1, done0, done1, resp_result1, resp_result2, busy,
        output mc_start, mc_op, mc_operand1, mc_operand2
    );

    // requesters plus MCycle view
    modport master (
        output req0, op0, a0, b0, req1, op1, a1, b1,
        output mc_result1, mc_result2, mc_busy,
        input  gnt0, gnt1, done0, done1, resp_result1, resp_result2, busy,
        input  mc_start, mc_op, mc_operand1, mc_operand2
    );

endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the requester that did not win last time wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = req0 & (~req1 | last_gnt);
    assign gnt1 = req1 & (~req0 | ~last_gnt);

endmodule

// File: rtl/mcycle_arbiter.sv
// Shares one MCycle multiply/divide unit between two requesters and sequences its Start/Busy protocol.
module mcycle_arbiter
    import mcycle_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RESET,
    mcycle_arbiter_if.slave bus
);

    arb_state_e       state;
    logic             owner;
    logic             last_gnt;
    logic             pick0;
    logic             pick1;
    logic             gnt0;
    logic             gnt1;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] opnd1_q;
    logic [WIDTH-1:0] opnd2_q;
    logic [WIDTH-1:0] res1_q;
    logic [WIDTH-1:0] res2_q;
    logic             start_q;
    logic             busy_q;
    logic             done0_q;
    logic             done1_q;

    rr_arb2 u_rr (
        .req0     (bus.req0),
        .req1     (bus.req1),
        .last_gnt (last_gnt),
        .gnt0     (pick0),
        .gnt1     (pick1)
    );

    // grants exist only in IDLE and never while reset is applied
    assign gnt0 = (state == IDLE) & ~RESET & pick0;
    assign gnt1 = (state == IDLE) & ~RESET & pick1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
            op_q     <= 2'b00;
            opnd1_q  <= '0;
            opnd2_q  <= '0;
            res1_q   <= '0;
            res2_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        op_q     <= gnt1 ? bus.op1 : bus.op0;
                        opnd1_q  <= gnt1 ? bus.a1  : bus.a0;
                        opnd2_q  <= gnt1 ? bus.b1  : bus.b0;
                        owner    <= gnt1;
                        last_gnt <= gnt1;
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // drop Start as soon as MCycle has taken it so it cannot restart
                    if (bus.mc_busy) begin
                        start_q <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.mc_busy) begin
                        res1_q  <= bus.mc_result1;
                        res2_q  <= bus.mc_result2;
                        done0_q <= ~owner;
                        done1_q <= owner;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.done0        = done0_q;
    assign bus.done1        = done1_q;
    assign bus.resp_result1 = res1_q;
    assign bus.resp_result2 = res2_q;
    assign bus.busy         = busy_q;
    assign bus.mc_start     = start_q;
    assign bus.mc_op        = op_q;
    assign bus.mc_operand1  = opnd1_q;
    assign bus.mc_operand2  = opnd2_q;

endmodule

// File: tb/tb_mcycle_arbiter.sv
// Directed bench for mcycle_arbiter at WIDTH=4 driving a behavioural multi-cycle MCycle unit.
module tb_mcycle_arbiter;
    import mcycle_pkg::*;

    localparam int unsigned W      = 4;
    localparam int unsigned MC_LAT = 3;
    localparam int unsigned TMO    = 60;

    logic clk = 1'b0;
    logic rst;

    int n_vec = 0;
    int n_err = 0;

    mcycle_arbiter_if #(.WIDTH(W)) bus ();

    mcycle_arbiter #(.WIDTH(W)) u_dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // behavioural MCycle: Busy rises with Start when idle, falls when results are valid
    logic         m_run;
    logic [3:0]   m_cnt;
    logic [W-1:0] m_r1;
    logic [W-1:0] m_r2;

    function automatic logic [2*W-1:0] mc_calc(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        logic signed [W-1:0]   q;
        logic signed [W-1:0]   r;
        case (op)
            MUL_S: begin
                sa = {{W{a[W-1]}}, a};
                sb = {{W{b[W-1]}}, b};
                return sa * sb;
            end
            MUL_U: return {{W{1'b0}}, a} * {{W{1'b0}}, b};
            DIV_S: begin
                if (b == '0) return {a, {W{1'b1}}};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == '0) return {a, {W{1'b1}}};
                return {a % b, a / b};
            end
        endcase
    endfunction

    assign bus.mc_busy    = m_run | bus.mc_start;
    assign bus.mc_result1 = m_r1;
    assign bus.mc_result2 = m_r2;

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 1'b0;
            m_cnt <= 4'd0;
            m_r1  <= '0;
            m_r2  <= '0;
        end else if (!m_run) begin
            if (bus.mc_start) begin
                m_run <= 1'b1;
                m_cnt <= 4'(MC_LAT);
            end
        end else if (m_cnt == 4'd0) begin
            m_run        <= 1'b0;
            {m_r2, m_r1} <= mc_calc(bus.mc_op, bus.mc_operand1, bus.mc_operand2);
        end else begin
            m_cnt <= m_cnt - 4'd1;
        end
    end

    // protocol monitors
    int   gnt0_cnt = 0, gnt1_cnt = 0, done0_cnt = 0, done1_cnt = 0;
    int   gnt_both = 0, done_both = 0, done_long = 0, start_in_wait = 0;
    logic done_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.gnt0) gnt0_cnt++;
        if (bus.gnt1) gnt1_cnt++;
        if (bus.done0) done0_cnt++;
        if (bus.done1) done1_cnt++;
        if (bus.gnt0 && bus.gnt1) gnt_both++;
        if (bus.done0 && bus.done1) done_both++;
        if (done_prev && (bus.done0 || bus.done1)) done_long++;
        done_prev = bus.done0 | bus.done1;
        if (bus.mc_start && m_run) start_in_wait++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.op0  = 2'b00;
        bus.op1  = 2'b00;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.a1   = '0;
        bus.b1   = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_gnt(input bit drop, output int who);
        who = -1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                who = bus.gnt1 ? 1 : 0;
                break;
            end
        end
        if (who < 0) check("gnt_timeout", 32'd1, 32'd0);
        else if (drop) begin
            @(posedge clk);
            #2;
            if (who == 0) bus.req0 = 1'b0;
            else bus.req1 = 1'b0;
        end
    endtask

    task automatic wait_done(output int who, output logic [W-1:0] r1, output logic [W-1:0] r2);
        who = -1;
        r1  = '0;
        r2  = '0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            if (bus.done0 || bus.done1) begin
                who = bus.done1 ? 1 : 0;
                r1  = bus.resp_result1;
                r2  = bus.resp_result2;
                break;
            end
        end
        if (who < 0) check("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           who;
        int           dwho;
        int           g0;
        int           d0;
        int           d1;
        logic [W-1:0] r1;
        logic [W-1:0] r2;

        // reset values
        apply_reset();
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_start", 32'(bus.mc_start), 32'd0);
        check("rst_op", 32'(bus.mc_op), 32'd0);
        check("rst_opnd1", 32'(bus.mc_operand1), 32'd0);
        check("rst_opnd2", 32'(bus.mc_operand2), 32'd0);
        check("rst_res1", 32'(bus.resp_result1), 32'd0);
        check("rst_res2", 32'(bus.resp_result2), 32'd0);
        check("rst_done", 32'({bus.done1, bus.done0}), 32'd0);
        check("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);

        // single requester, signed mul -3 * 2
        @(posedge clk);
        #2;
        bus.op0 = MUL_S; bus.a0 = 4'b1101; bus.b0 = 4'b0010; bus.req0 = 1'b1;
        wait_gnt(1'b1, who);
        check("t1_gnt_who", 32'(who), 32'd0);
        wait_done(dwho, r1, r2);
        check("t1_done_who", 32'(dwho), 32'd0);
        check("t1_res1", 32'(r1), 32'hA);
        check("t1_res2", 32'(r2), 32'hF);
        repeat (3) @(negedge clk);
        check("t1_gnt0_cnt", 32'(gnt0_cnt), 32'd1);
        check("t1_done0_cnt", 32'(done0_cnt), 32'd1);
        check("t1_done1_cnt", 32'(done1_cnt), 32'd0);

        // simultaneous requests after reset: requester 0 wins the first tie
        apply_reset();
        bus.op0 = MUL_S; bus.a0 = 4'b1111; bus.b0 = 4'b1111;
        bus.op1 = DIV_U; bus.a1 = 4'b1000; bus.b1 = 4'b0100;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_gnt(1'b1, who);
        check("t2_first", 32'(who), 32'd0);
        wait_done(dwho, r1, r2);
        check("t2_done0_who", 32'(dwho), 32'd0);
        check("t2_res1_a", 32'(r1), 32'h1);
        check("t2_res2_a", 32'(r2), 32'h0);
        wait_gnt(1'b1, who);
        check("t2_second", 32'(who), 32'd1);
        check("t2_mc_op", 32'(bus.mc_op), 32'(DIV_U));
        check("t2_mc_opnd1", 32'(bus.mc_operand1), 32'h8);
        wait_done(dwho, r1, r2);
        check("t2_done1_who", 32'(dwho), 32'd1);
        check("t2_res1_b", 32'(r1), 32'h2);
        check("t2_res2_b", 32'(r2), 32'h0);

        // both hold requests for four operations: strict alternation
        @(posedge clk);
        #2;
        bus.op0 = MUL_U; bus.a0 = 4'b0011; bus.b0 = 4'b0101;
        bus.op1 = DIV_U; bus.a1 = 4'b1001; bus.b1 = 4'b0010;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(1'b0, who);
            check("t3_order", 32'(who), 32'(k % 2));
            if (k == 3) begin
                @(posedge clk);
                #2;
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
            wait_done(dwho, r1, r2);
            check("t3_done_who", 32'(dwho), 32'(k % 2));
            check("t3_res1", 32'(r1), (k % 2 == 1) ? 32'h4 : 32'hF);
            check("t3_res2", 32'(r2), (k % 2 == 1) ? 32'h1 : 32'h0);
        end
        repeat (3) @(negedge clk);
        check("t3_start_in_wait", 32'(start_in_wait), 32'd0);

        // requester 0 withdraws while requester 1 is being served
        @(posedge clk);
        #2;
        bus.op1 = DIV_S; bus.a1 = 4'b1100; bus.b1 = 4'b0011; bus.req1 = 1'b1;
        g0 = gnt0_cnt;
        d0 = done0_cnt;
        wait_gnt(1'b1, who);
        check("t4_gnt_who", 32'(who), 32'd1);
        bus.op0 = MUL_U; bus.a0 = 4'b1010; bus.b0 = 4'b1010; bus.req0 = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2 bus.req0 = 1'b0;
        wait_done(dwho, r1, r2);
        check("t4_done_who", 32'(dwho), 32'd1);
        check("t4_res1", 32'(r1), 32'hF);
        check("t4_res2", 32'(r2), 32'hF);
        repeat (8) @(negedge clk);
        check("t4_no_gnt0", 32'(gnt0_cnt), 32'(g0));
        check("t4_no_done0", 32'(done0_cnt), 32'(d0));

        // reset during WAIT of 15 x 15 unsigned
        @(posedge clk);
        #2;
        bus.op0 = MUL_U; bus.a0 = 4'b1111; bus.b0 = 4'b1111; bus.req0 = 1'b1;
        wait_gnt(1'b1, who);
        check("t5_gnt_who", 32'(who), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_start", 32'(bus.mc_start), 32'd0);
        check("t5_res1", 32'(bus.resp_result1), 32'd0);
        check("t5_res2", 32'(bus.resp_result2), 32'd0);
        d0 = done0_cnt;
        d1 = done1_cnt;
        repeat (8) @(negedge clk);
        check("t5_no_done", 32'((done0_cnt - d0) + (done1_cnt - d1)), 32'd0);
        @(posedge clk);
        #2 bus.req0 = 1'b1;
        wait_gnt(1'b1, who);
        check("t5_regnt", 32'(who), 32'd0);
        wait_done(dwho, r1, r2);
        check("t5_redone", 32'(dwho), 32'd0);
        check("t5_reres1", 32'(r1), 32'h1);
        check("t5_reres2", 32'(r2), 32'hE);

        // signed 0 / -2 and Busy window
        @(posedge clk);
        #2;
        bus.op0 = DIV_S; bus.a0 = 4'b0000; bus.b0 = 4'b1110; bus.req0 = 1'b1;
        check("t6_busy_idle", 32'(bus.busy), 32'd0);
        wait_gnt(1'b1, who);
        check("t6_gnt_who", 32'(who), 32'd0);
        check("t6_busy_issue", 32'(bus.busy), 32'd1);
        check("t6_start_issue", 32'(bus.mc_start), 32'd1);
        check("t6_mc_op", 32'(bus.mc_op), 32'(DIV_S));
        check("t6_mc_opnd2", 32'(bus.mc_operand2), 32'hE);
        wait_done(dwho, r1, r2);
        check("t6_done_who", 32'(dwho), 32'd0);
        check("t6_res1", 32'(r1), 32'h0);
        check("t6_res2", 32'(r2), 32'h0);
        check("t6_busy_resp", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("t6_busy_after", 32'(bus.busy), 32'd0);

        repeat (2) @(negedge clk);
        check("gnt_both", 32'(gnt_both), 32'd0);
        check("done_both", 32'(done_both), 32'd0);
        check("done_long", 32'(done_long), 32'd0);
        check("start_in_wait", 32'(start_in_wait), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mcycle_arbiter.md
Name: mcycle_arbiter

Overview:
- Shares one MCycle multiply/divide unit between two requesters, e.g. a pipeline issue port and a debug/secondary port.
- Per-requester request/grant handshake with round-robin arbitration.
- Latches the operands and sequences the MCycle Start/Busy protocol.
- Returns both result words with a per-requester one-cycle Done pulse.
- Sits between the requesters and the MCycle instance; drives the MCycle instance directly.

Parameters:
- WIDTH, 32, operand/result width; must match the MCycle instance.

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  synchronous, active-high reset
- Req0  in  1  requester 0 wants an operation; held until Gnt0
- Op0  in  2  requester 0 MCycleOp: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div
- A0  in  WIDTH  requester 0 Operand1 (multiplicand/dividend)
- B0  in  WIDTH  requester 0 Operand2 (multiplier/divisor)
- Gnt0  out  1  combinational; request accepted at this clock edge
- Done0  out  1  one-cycle pulse; RespResult1/2 valid for requester 0
- Req1, Op1, A1, B1, Gnt1, Done1  same as requester 0, for requester 1
- RespResult1  out  WIDTH  mul: product LSW; div: quotient
- RespResult2  out  WIDTH  mul: product MSW; div: remainder
- Busy  out  1  high whenever state != IDLE
- MC_Start  out  1  to MCycle Start
- MC_Op  out  2  to MCycle MCycleOp
- MC_Operand1  out  WIDTH  to MCycle Operand1
- MC_Operand2  out  WIDTH  to MCycle Operand2
- MC_Result1  in  WIDTH  from MCycle Result1
- MC_Result2  in  WIDTH  from MCycle Result2
- MC_Busy  in  1  from MCycle Busy. Rises combinationally in the same cycle Start is seen in MCycle idle; falls the cycle results are valid.

Behaviour:
- Clock and reset: one clock CLK; RESET synchronous, active-high.
- Reset values: state IDLE; Gnt0/1=0, Done0/1=0, Busy=0, MC_Start=0, MC_Op=00, MC_Operand1/2=0, RespResult1/2=0, Owner=0, LastGnt=1 (so requester 0 wins the first tie).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any Req is high, pick a winner: a single requester wins outright; if both request, the one != LastGnt wins.
  - Assert its Gnt combinationally.
  - At the edge: latch Op/A/B into MC_Op/MC_Operand1/2, set Owner and LastGnt to the winner, go to ISSUE.
  - Loser's Gnt stays 0; it must keep Req and operands stable.
- ISSUE:
  - MC_Start=1.
  - When MC_Busy=1 this cycle, go to WAIT (MC_Start deasserts in WAIT, so MCycle never back-to-back restarts).
  - Otherwise stay in ISSUE.
- WAIT:
  - MC_Start=0; MC_Op/MC_Operand1/2 held stable.
  - When MC_Busy=0: capture MC_Result1/2 into RespResult1/2, go to RESP.
- RESP:
  - Done[Owner]=1 for exactly one cycle; go to IDLE.
  - RespResult1/2 hold until the next capture.
- Latency: accept edge k; ISSUE cycle k+1; RESP at MCycle compute time + 2 cycles after ISSUE. No grants in ISSUE, WAIT or RESP.
- Gnt0 and Gnt1 are never both high. Done0 and Done1 are never both high.
- Req deasserted before its grant: the request is withdrawn with no side effect.
- Requester re-requesting in the same cycle as its Done: eligible in the following IDLE cycle, subject to round-robin.
- No data transformation: results pass through bit-exact at WIDTH; sign handling is MCycle's job.
- Reset in any state: all outputs return to reset values at that edge. MCycle shares RESET, so no stale Done is ever emitted.

Decomposition:
- Package mcycle_pkg:
  - MCycleOp codes MUL_S=2'b00, MUL_U=2'b01, DIV_S=2'b10, DIV_U=2'b11.
  - FSM state encoding IDLE/ISSUE/WAIT/RESP.
- One natural sub-module: rr_arb2 (combinational 2-way round-robin pick; inputs Req0, Req1, LastGnt; outputs Gnt0, Gnt1).
- Testbench instantiates mcycle_arbiter with a real MCycle, WIDTH=4.

Test Plan:
- Req0 only, Op=00, A0=4'b1101, B0=4'b0010 -> Gnt0 one cycle; Done0 pulse; RespResult1=4'b1010, RespResult2=4'b1111 (-6); Done1 never high.
- Req0 and Req1 simultaneously after reset; Req0 signed mul 1111x1111, Req1 unsigned div 1000/0100 -> requester 0 first (RespResult1=0001, RespResult2=0000); requester 1 next (RespResult1=0010, RespResult2=0000).
- Both requesters hold Req continuously for 4 ops -> grants alternate 0,1,0,1; exactly one Done per grant; MC_Start never high in WAIT.
- Req1 signed div A1=1100, B1=0011 while Req0 is withdrawn before its grant -> only Done1, RespResult1=1111, RespResult2=1111.
- RESET asserted for 1 cycle during WAIT of a 15x15 unsigned mul -> next edge: Busy=0, MC_Start=0, RespResult1/2=0; no Done; a subsequent Req0 is served normally.
- Req0 signed div 0000/1110 -> RespResult1=0000, RespResult2=0000; Busy high from ISSUE through RESP only.
